// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared states, select encodings, ALU codes and opcodes for the multicycle controller
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } statetype_t;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
endpackage

// File: rtl/aludec.sv
// aludec: ALU operation decode from ALUOp, op[5], funct3 and funct7b5
module aludec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alucontrol
);
  logic [3:0] fn;
  // R/I-type function decode; subtract only for R-type with funct7b5
  always_comb begin
    fn = ALU_ADD;
    case (funct3)
      3'b000: fn = op5 && funct7b5 ? ALU_SUB : ALU_ADD;
      3'b001: fn = ALU_SLL;
      3'b010: fn = ALU_SLT;
      3'b011: fn = ALU_SLTU;
      3'b100: fn = ALU_XOR;
      3'b101: fn = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: fn = ALU_OR;
      default: fn = ALU_AND;
    endcase
  end
  // address/PC arithmetic adds, branches subtract, otherwise use the function decode
  always_comb alucontrol = aluop == ALUOP_SUB ? ALU_SUB : aluop == ALUOP_FUNCT ? fn : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM with MemReady stalls, bus timeout and illegal trap; RV_FULL_BRANCH_EN adds BLT/BGE/BLTU/BGEU
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LessS,
  input  logic       LessU,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Illegal,
  output logic       BusFault
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  statetype_t state, state_next;
  logic [CW-1:0] cnt;
  logic [1:0] aluop;
  logic take_branch, mem_wait, at_limit;
  // a memory state is stalled; the limit only counts while still stalled so MemReady wins
  always_comb begin
    mem_wait = (state == FETCH || state == MEMREAD || state == MEMWRITE) && !MemReady;
    at_limit = mem_wait && cnt == CW'(TIMEOUT - 1);
  end
`ifdef RV_FULL_BRANCH_EN
  // full branch set from funct3 and ALU flags; 010/011 never branch
  always_comb take_branch = funct3 == 3'b000 ? Zero : funct3 == 3'b001 ? !Zero :
                            funct3 == 3'b100 ? LessS : funct3 == 3'b101 ? !LessS :
                            funct3 == 3'b110 ? LessU : funct3 == 3'b111 ? !LessU : 1'b0;
`else
  logic unused_flags;
  assign unused_flags = LessS ^ LessU;
  // only BEQ/BNE; other branch encodings fall through
  always_comb take_branch = funct3 == 3'b000 ? Zero : funct3 == 3'b001 ? !Zero : 1'b0;
`endif
  // state, stall counter and sticky fault flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt <= '0;
      Illegal <= 1'b0;
      BusFault <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= mem_wait && !at_limit ? cnt + CW'(1) : '0;
      Illegal <= Illegal || (state == DECODE && state_next == TRAP);
      BusFault <= BusFault || at_limit;
    end
  end
  // next state and datapath controls
  always_comb begin
    state_next = TRAP;
    MemReq = 1'b0;
    AdrSrc = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    RegWrite = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_B;
    aluop = ALUOP_ADD;
    case (state)
      FETCH: begin
        MemReq = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite = MemReady;
        PCWrite = MemReady;
        state_next = MemReady ? DECODE : at_limit ? TRAP : FETCH;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_next = op == OP_LOAD || op == OP_STORE ? MEMADR : op == OP_RTYPE ? EXECR :
                     op == OP_ITYPE ? EXECI : op == OP_BRANCH ? BRANCH : op == OP_JAL ? JAL : TRAP;
      end
      MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        state_next = MemReady ? MEMWB : at_limit ? TRAP : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        MemReq = 1'b1;
        MemWrite = 1'b1;
        AdrSrc = 1'b1;
        state_next = MemReady ? FETCH : at_limit ? TRAP : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA = SRCA_A;
        aluop = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        aluop = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA = SRCA_A;
        aluop = ALUOP_SUB;
        PCWrite = take_branch;
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = TRAP;
    endcase
  end
  // immediate format follows the opcode in every state
  always_comb ImmSrc = op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  aludec u_aludec (
    .aluop(aluop),
    .op5(op[5]),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .alucontrol(ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized self-checking bench against a per-cycle phase model of the controller
module tb_multicycle_controller;
  localparam logic [6:0] OP_L = 7'b0000011, OP_S = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_B = 7'b1100011, OP_J = 7'b1101111;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = OP_R;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0, LessS = 1'b0, LessU = 1'b0, MemReady = 1'b0;
  logic MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, Illegal, BusFault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;
  int n_cmp = 0, n_err = 0, force_lu = -1;
  typedef struct {
    logic [15:0] v;
    logic [15:0] m;
    int rdy;
    bit br;
    logic [1:0] fl;
  } ph_t;
  ph_t q[$];
  multicycle_controller #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LessS(LessS), .LessU(LessU), .MemReady(MemReady),
    .MemReq(MemReq), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal),
    .BusFault(BusFault)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic ph_t ph(int mr, int ar, int mw, int ir, int pw, int rw, int rs, int sa,
                             int sb, int alu, int rdy, bit br = 1'b0, logic [1:0] fl = 2'b00);
    ph_t p;
    p.v = '0;
    p.m = 16'hBC00;
    p.v[15] = mr[0];
    p.v[13] = mw[0];
    p.v[12] = ir[0];
    p.v[11] = pw[0];
    p.v[10] = rw[0];
    if (ar >= 0) begin p.v[14] = ar[0]; p.m[14] = 1'b1; end
    if (rs >= 0) begin p.v[9:8] = rs[1:0]; p.m[9:8] = 2'b11; end
    if (sa >= 0) begin p.v[7:6] = sa[1:0]; p.m[7:6] = 2'b11; end
    if (sb >= 0) begin p.v[5:4] = sb[1:0]; p.m[5:4] = 2'b11; end
    if (alu >= 0) begin p.v[3:0] = alu[3:0]; p.m[3:0] = 4'hF; end
    p.rdy = rdy;
    p.br = br;
    p.fl = fl;
    return p;
  endfunction
  function automatic logic take(logic [2:0] f3, logic z, logic ls, logic lu);
    logic [7:0] t;
    t = {!lu, lu, !ls, ls, 1'b0, 1'b0, !z, z};
`ifdef RV_FULL_BRANCH_EN
    return t[f3];
`else
    return f3 < 3'd2 ? t[f3] : 1'b0;
`endif
  endfunction
  function automatic int alu_ref(logic op5, logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return op5 && f7 ? 1 : 0;
      3'd1: return 2;
      3'd2: return 3;
      3'd3: return 4;
      3'd4: return 5;
      3'd5: return f7 ? 7 : 6;
      3'd6: return 8;
      default: return 9;
    endcase
  endfunction
  function automatic int imm_ref(logic [6:0] o);
    case (o)
      OP_L, OP_I: return 0;
      OP_S: return 1;
      OP_B: return 2;
      OP_J: return 3;
      default: return -1;
    endcase
  endfunction
  function automatic bit legal(logic [6:0] o);
    return o inside {OP_L, OP_S, OP_R, OP_I, OP_B, OP_J};
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    MemReady = 1'($urandom);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic play(string name);
    ph_t p;
    logic [15:0] obs, exp;
    int ie;
    while (q.size() > 0) begin
      p = q.pop_front();
      MemReady = p.rdy == 2 ? 1'($urandom) : p.rdy[0];
      Zero = 1'($urandom);
      LessS = 1'($urandom);
      LessU = force_lu < 0 ? 1'($urandom) : force_lu[0];
      #1;
      exp = p.v;
      if (p.br) exp[11] = take(funct3, Zero, LessS, LessU);
      obs = {MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl};
      n_cmp++;
      if ((obs & p.m) !== (exp & p.m)) begin
        n_err++;
        $display("FAIL %s ctrl: got %h required %h (mask %h)", name, obs, exp, p.m);
      end
      ie = imm_ref(op);
      if (ie >= 0) begin
        n_cmp++;
        if (ImmSrc !== ie[1:0]) begin
          n_err++;
          $display("FAIL %s ImmSrc: got %b required %b", name, ImmSrc, ie[1:0]);
        end
      end
      n_cmp++;
      if ({Illegal, BusFault} !== p.fl) begin
        n_err++;
        $display("FAIL %s flags: got Illegal/BusFault %b required %b", name, {Illegal, BusFault}, p.fl);
      end
      @(negedge clk);
    end
  endtask
  task automatic push_fetch(int n);
    for (int i = 0; i < n; i++) q.push_back(ph(1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    q.push_back(ph(1, 0, 0, 1, 1, 0, 2, 0, 2, 0, 1));
  endtask
  task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, logic f7, int fw, int mw);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    push_fetch(fw);
    q.push_back(ph(0, -1, 0, 0, 0, 0, -1, 1, 1, 0, 2));
    case (o)
      OP_L: begin
        q.push_back(ph(0, -1, 0, 0, 0, 0, -1, 2, 1, 0, 2));
        for (int i = 0; i < mw; i++) q.push_back(ph(1, 1, 0, 0, 0, 0, -1, -1, -1, -1, 0));
        q.push_back(ph(1, 1, 0, 0, 0, 0, -1, -1, -1, -1, 1));
        q.push_back(ph(0, -1, 0, 0, 0, 1, 1, -1, -1, -1, 2));
      end
      OP_S: begin
        q.push_back(ph(0, -1, 0, 0, 0, 0, -1, 2, 1, 0, 2));
        for (int i = 0; i < mw; i++) q.push_back(ph(1, 1, 1, 0, 0, 0, -1, -1, -1, -1, 0));
        q.push_back(ph(1, 1, 1, 0, 0, 0, -1, -1, -1, -1, 1));
      end
      OP_R, OP_I: begin
        q.push_back(ph(0, -1, 0, 0, 0, 0, -1, 2, o == OP_R ? 0 : 1, alu_ref(o[5], f3, f7), 2));
        q.push_back(ph(0, -1, 0, 0, 0, 1, 0, -1, -1, -1, 2));
      end
      OP_B: q.push_back(ph(0, -1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1'b1));
      OP_J: begin
        q.push_back(ph(0, -1, 0, 0, 1, 0, 0, 1, 2, 0, 2));
        q.push_back(ph(0, -1, 0, 0, 0, 1, 0, -1, -1, -1, 2));
      end
      default: ;
    endcase
    play(name);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    MemReady = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    #1;
    n_cmp++;
    if (MemReq !== 1'b1) begin n_err++; $display("FAIL reset MemReq: got %b required 1", MemReq); end
    n_cmp++;
    if ({AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite} !== 5'b0) begin
      n_err++;
      $display("FAIL reset strobes: got %b required 00000", {AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite});
    end
    n_cmp++;
    if ({Illegal, BusFault} !== 2'b00) begin n_err++; $display("FAIL reset flags: got %b required 00", {Illegal, BusFault}); end
    @(negedge clk);
  endtask
  task automatic test_rtype();
    do_reset();
    run_instr("rtype", OP_R, 3'b000, 1'b1, 0, 0);
    run_instr("itype", OP_I, 3'b101, 1'b1, 0, 0);
  endtask
  task automatic test_load_stall();
    do_reset();
    run_instr("load_stall", OP_L, 3'b010, 1'b0, 0, 3);
  endtask
  task automatic test_branch();
    do_reset();
    force_lu = 1;
    run_instr("bltu_taken", OP_B, 3'b110, 1'b0, 0, 0);
    force_lu = 0;
    run_instr("bltu_not_taken", OP_B, 3'b110, 1'b0, 0, 0);
    force_lu = -1;
  endtask
  task automatic test_random();
    logic [6:0] ops [6] = '{OP_L, OP_S, OP_R, OP_I, OP_B, OP_J};
    do_reset();
    repeat (80) run_instr("random", ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom),
                          $urandom_range(0, 7), $urandom_range(0, 7));
  endtask
  task automatic test_illegal();
    logic [6:0] o;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      o = 7'h7f;
      if (k > 0) do o = 7'($urandom); while (legal(o));
      op = o;
      push_fetch($urandom_range(0, 3));
      q.push_back(ph(0, -1, 0, 0, 0, 0, -1, 1, 1, 0, 2));
      repeat (6) q.push_back(ph(0, -1, 0, 0, 0, 0, -1, -1, -1, -1, 2, 1'b0, 2'b10));
      play("illegal");
    end
    do_reset();
    #1;
    n_cmp++;
    if (Illegal !== 1'b0) begin n_err++; $display("FAIL illegal_clear: got %b required 0", Illegal); end
    @(negedge clk);
  endtask
  task automatic test_timeout();
    do_reset();
    op = OP_R;
    repeat (8) q.push_back(ph(1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    repeat (4) q.push_back(ph(0, -1, 0, 0, 0, 0, -1, -1, -1, -1, 2, 1'b0, 2'b01));
    play("timeout");
    do_reset();
    run_instr("timeout_edge", OP_R, 3'b100, 1'b0, 7, 0);
    run_instr("timeout_edge_load", OP_L, 3'b010, 1'b0, 0, 7);
  endtask
  task automatic test_reset_memwrite();
    do_reset();
    op = OP_S;
    funct3 = 3'b010;
    push_fetch(0);
    q.push_back(ph(0, -1, 0, 0, 0, 0, -1, 1, 1, 0, 2));
    q.push_back(ph(0, -1, 0, 0, 0, 0, -1, 2, 1, 0, 2));
    repeat (3) q.push_back(ph(1, 1, 1, 0, 0, 0, -1, -1, -1, -1, 0));
    play("memwrite_stall");
    reset = 1'b1;
    MemReady = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    #1;
    n_cmp++;
    if ({MemReq, AdrSrc, MemWrite} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_memwrite: got MemReq/AdrSrc/MemWrite %b required 100", {MemReq, AdrSrc, MemWrite});
    end
    n_cmp++;
    if ({Illegal, BusFault} !== 2'b00) begin n_err++; $display("FAIL reset_memwrite flags: got %b required 00", {Illegal, BusFault}); end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_load_stall();
    test_branch();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_memwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core with MMIO. It sequences a shared-memory datapath (PC, IR, OldPC, A/B, ALUOut, Data registers) over several cycles per instruction. It stalls on a memory ready handshake so slow MMIO peripherals can hold the bus, and it flags illegal opcodes and bus timeouts. It sits beside the datapath and drives every mux select and write enable, taking only `op`, `funct3`, `funct7b5` and the ALU flags back.

## Interface
- `TIMEOUT`, default 256: maximum number of consecutive cycles a memory state may wait on `MemReady` before the bus is declared faulted.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7b5` in 1: IR[30].
- `Zero` `LessS` `LessU` in 1 each: ALU compare flags.
- `MemReady` in 1: memory/MMIO has completed the current access this cycle.
- `MemReq` out 1: memory access requested.
- `AdrSrc` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: store strobe.
- `IRWrite` out 1: load IR and OldPC.
- `PCWrite` out 1: load PC from Result.
- `RegWrite` out 1: register-file write.
- `ResultSrc` out 2: Result select, 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select, 00 = PC, 01 = OldPC, 10 = A.
- `ALUSrcB` out 2: ALU B select, 00 = B, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: immediate format, I = 00, S = 01, B = 10, J = 11.
- `ALUControl` out 4: ALU operation.
- `Illegal` out 1: sticky, unsupported opcode seen.
- `BusFault` out 1: sticky, `MemReady` timeout.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- FETCH:
  - Outputs: `MemReq` = 1, `AdrSrc` = 0, `ALUSrcA` = 00, `ALUSrcB` = 10, ALUOp = 00, `ResultSrc` = 10.
  - `IRWrite` and `PCWrite` assert only in the cycle `MemReady` = 1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: `ALUSrcA` = 01, `ALUSrcB` = 01, ALUOp = 00 (precomputes the branch target). Next state by `op`:
  - 0000011 (load) and 0100011 (store) -> MEMADR.
  - 0110011 (R-type) -> EXECR.
  - 0010011 (I-type ALU) -> EXECI.
  - 1100011 (branch) -> BRANCH.
  - 1101111 (JAL) -> JAL.
  - Any other opcode -> TRAP.
- MEMADR: `ALUSrcA` = 10, `ALUSrcB` = 01, ALUOp = 00. Go to MEMREAD if `op[5]` = 0, else MEMWRITE.
- MEMREAD: `MemReq`, `AdrSrc` = 1. Hold until `MemReady`, then go to MEMWB.
- MEMWB: `ResultSrc` = 01, `RegWrite`. Go to FETCH.
- MEMWRITE: `MemReq`, `MemWrite`, `AdrSrc` = 1, held steady until `MemReady`. Then go to FETCH.
- EXECR: `ALUSrcA` = 10, `ALUSrcB` = 00, ALUOp = 10. Go to ALUWB.
- EXECI: `ALUSrcA` = 10, `ALUSrcB` = 01, ALUOp = 10. Go to ALUWB.
- ALUWB: `ResultSrc` = 00, `RegWrite`. Go to FETCH.
- BRANCH: `ALUSrcA` = 10, `ALUSrcB` = 00, ALUOp = 01, `ResultSrc` = 00. `PCWrite` = TakeBranch(`funct3`, flags). Go to FETCH.
- JAL: `ALUSrcA` = 01, `ALUSrcB` = 10, ALUOp = 00, `ResultSrc` = 00, `PCWrite` = 1. Go to ALUWB.
- TRAP: all strobes 0. Stays in TRAP until `reset`.
- `ImmSrc` decodes combinationally from `op` in every state: load/I-type = 00, store = 01, branch = 10, JAL = 11.
- `ALUControl` is produced by `aludec` from ALUOp, `op[5]`, `funct3` and `funct7b5`.
- Timeout counter:
  - Cleared on every transition.
  - Increments each cycle a memory state (FETCH, MEMREAD, MEMWRITE) waits with `MemReady` = 0.
  - On reaching `TIMEOUT`-1 while still waiting: set `BusFault` and go to TRAP.
  - Width is $clog2(`TIMEOUT`)+1.
- `Illegal` sets on the DECODE -> TRAP transition.

## Timing
- Reset (synchronous):
  - State = FETCH, counter = 0, `Illegal` = 0, `BusFault` = 0.
  - Because FETCH is combinational, `MemReq` = 1 in the first post-reset cycle. All other strobes are 0.
- All outputs are Moore functions of state, except these, which are combinational in the current cycle:
  - `IRWrite` and `PCWrite` in FETCH (gated by `MemReady`).
  - `PCWrite` in BRANCH.
  - `ImmSrc`.
- Cycles with zero-wait memory: load 5, store 4, R/I-type 4, branch 3, JAL 4.
- Each wait cycle adds one cycle to the state it occurs in.
- `MemReady` is ignored outside FETCH, MEMREAD and MEMWRITE.
- `reset` takes priority over `MemReady`, over the timeout and over TRAP.
- `MemReady` and the timeout reaching its limit in the same cycle: `MemReady` wins, no fault.

## Configuration
- `RV_FULL_BRANCH_EN` defined: TakeBranch covers the full branch set.
  - BEQ = `Zero`, BNE = ~`Zero`.
  - BLT = `LessS`, BGE = ~`LessS`.
  - BLTU = `LessU`, BGEU = ~`LessU`.
  - `funct3` 010 and 011 never branch.
- `RV_FULL_BRANCH_EN` undefined: only BEQ (`funct3` 000, taken on `Zero`) and BNE (`funct3` 001, taken on ~`Zero`). Other branch `funct3` values fall through as not-taken.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - `statetype_t` enum.
  - ALUOp constants.
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings.
  - Opcode localparams.
- One sub-module: the existing `aludec`, instantiated unchanged.
- TakeBranch is an in-module `always_comb` block.

## Test plan
- Reset, then `op` = 0110011 with `MemReady` held 1 -> states FETCH, DECODE, EXECR, ALUWB, FETCH; `RegWrite` = 1 in cycle 4 only.
- Load with `MemReady` low for 3 cycles in MEMREAD -> `MemReq` = 1 and `AdrSrc` = 1 held for 4 cycles; `RegWrite` with `ResultSrc` = 01 one cycle after `MemReady`.
- BLTU (`funct3` 110) with `LessU` = 1 -> `PCWrite` = 1 in BRANCH. With `LessU` = 0 -> `PCWrite` = 0. With the macro undefined -> `PCWrite` = 0 in both cases.
- `op` = 1111111 -> TRAP; `Illegal` = 1 and stays 1 until `reset`; no strobes asserted.
- `TIMEOUT` = 8, `MemReady` stuck at 0 in FETCH -> `BusFault` set after 8 cycles, then TRAP. Second run with `MemReady` = 1 in cycle 8 -> no fault.
- `reset` asserted mid-MEMWRITE stall -> next cycle in FETCH with `MemWrite` = 0 and both flags clear.
